imem_responder: RTL and testbench

- Instruction-memory responder for the MIPS fetch path. Receives fetch addresses (driven from the PC) over a valid/ready request channel and returns the 32-bit instruction word after a fixed, parameterised latency over a valid/ready response channel.
- Holds a word-addressed instruction array, loaded through a side write port by the testbench/loader.
- Flags misaligned and out-of-range fetch addresses.

---
 rtl/imem_responder_if.sv | 31 +++
 rtl/imem_responder.sv | 115 +++++++++++
 tb/tb_imem_responder.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// Fetch request/response channel between the PC side (master) and the
// instruction-memory responder (slave).
interface imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic        resp_err;

  modport master (
    output req_valid,
    output req_addr,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_instr,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_instr,
    output resp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: word array with a side write port, serving one
// fetch at a time after a fixed latency and flagging misaligned/out-of-range PCs.
module imem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_responder_if.slave       bus,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [31:0]           wr_data
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Loaded on acceptance so that resp_valid rises exactly LATENCY edges later.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_instr_q, resp_instr_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] mem_q [DEPTH];

  logic                  req_ready;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  fetch_err;
  logic [DEPTH_LOG2-1:0] fetch_idx;
  logic [31:0]           fetch_word;

  assign req_ready    = (state_q == IDLE) && reset;
  assign misaligned   = addr_q[1:0] != 2'b00;
  assign out_of_range = (addr_q >> (DEPTH_LOG2 + 2)) != 32'd0;
  assign fetch_err    = misaligned | out_of_range;
  assign fetch_idx    = addr_q[DEPTH_LOG2+1:2];
  // Array read sees the pre-edge contents, so a write on the RESP-entry edge is not returned.
  assign fetch_word   = mem_q[fetch_idx];

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_instr = resp_instr_q;
  assign bus.resp_err   = resp_err_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    resp_valid_d = resp_valid_q;
    resp_instr_d = resp_instr_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready) begin
          addr_d  = bus.req_addr;
          cnt_d   = CNT_LOAD;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = fetch_err;
          resp_instr_d = fetch_err ? 32'h0000_0000 : fetch_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_instr_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      resp_instr_q <= resp_instr_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // The array is deliberately not cleared by reset; writes are only blocked while it is held.
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end
endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: a LATENCY=2 and a LATENCY=1 instance share
// one write port and are compared against a cycle-level reference model.
module tb_imem_responder;
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  resp_ready;
  logic [1:0]  req_ready_a;
  logic [1:0]  resp_valid_a;
  logic [1:0]  resp_err_a;
  logic [31:0] req_addr [2];
  logic [31:0] resp_instr_a [2];
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] ref_mem [256];
  bit          m_busy [2];
  bit          m_resp [2];
  int          m_acc [2];
  logic [31:0] m_addr [2];
  exp_t        q0[$];
  exp_t        q1[$];

  imem_responder_if bus0();
  imem_responder_if bus1();

  assign bus0.req_valid  = req_valid[0];
  assign bus0.req_addr   = req_addr[0];
  assign bus0.resp_ready = resp_ready[0];
  assign bus1.req_valid  = req_valid[1];
  assign bus1.req_addr   = req_addr[1];
  assign bus1.resp_ready = resp_ready[1];

  assign req_ready_a[0]  = bus0.req_ready;
  assign resp_valid_a[0] = bus0.resp_valid;
  assign resp_err_a[0]   = bus0.resp_err;
  assign resp_instr_a[0] = bus0.resp_instr;
  assign req_ready_a[1]  = bus1.req_ready;
  assign resp_valid_a[1] = bus1.resp_valid;
  assign resp_err_a[1]   = bus1.resp_err;
  assign resp_instr_a[1] = bus1.resp_instr;

  imem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .bus(bus0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  imem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  function automatic int lat(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic exp_t ref_fetch(logic [31:0] a);
    exp_t e;
    if ((a % 4) != 0 || a >= 32'd1024) begin
      e.instr = 32'h0;
      e.err   = 1'b1;
    end else begin
      e.instr = ref_mem[8'(a / 4)];
      e.err   = 1'b0;
    end
    return e;
  endfunction

  function automatic int q_size(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t q_front(int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic q_push(int k, exp_t e);
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic q_pop(int k);
    if (k == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  task automatic q_clear(int k);
    if (k == 0) q0.delete();
    else q1.delete();
  endtask

  task automatic check_output(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s[%0d] actual=%h expected=%h at cycle %0d", name, k, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(string name, int k);
    checks++;
    errors++;
    $display("[TB] FAIL %s[%0d] timed out at cycle %0d", name, k, cyc);
  endtask

  // Reference model: a fetch accepted at edge T answers at edge T+LATENCY with the
  // array contents from before that edge's write; reset discards anything in flight.
  initial forever begin
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_busy[k] = 1'b0;
        m_resp[k] = 1'b0;
        q_clear(k);
      end else if (m_resp[k]) begin
        if (resp_ready[k]) begin
          m_busy[k] = 1'b0;
          m_resp[k] = 1'b0;
        end
      end else if (m_busy[k]) begin
        if (cyc == m_acc[k] + lat(k)) begin
          q_push(k, ref_fetch(m_addr[k]));
          m_resp[k] = 1'b1;
        end
      end else if (req_valid[k]) begin
        m_busy[k] = 1'b1;
        m_acc[k]  = cyc;
        m_addr[k] = req_addr[k];
      end
    end
    if (reset && wr_en) ref_mem[wr_addr] = wr_data;
  end

  // Monitor: compares every cycle on the falling edge; pops on the response handshake.
  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_output("req_ready", k, 32'(req_ready_a[k]), 32'(!m_busy[k] && reset));
      check_output("resp_valid", k, 32'(resp_valid_a[k]), 32'(q_size(k) > 0));
      if (resp_valid_a[k] && q_size(k) > 0) begin
        check_output("resp_instr", k, resp_instr_a[k], q_front(k).instr);
        check_output("resp_err", k, 32'(resp_err_a[k]), 32'(q_front(k).err));
        if (resp_ready[k]) q_pop(k);
      end
    end
  end

  task automatic apply_write(logic [7:0] a, logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  // One complete fetch on instance k; wr_off>0 lands a write on edge accept+wr_off.
  task automatic apply_fetch(int k, logic [31:0] addr, int stall, int wr_off,
                             logic [7:0] wa, logic [31:0] wd);
    int n;
    req_addr[k]  = addr;
    req_valid[k] = 1'b1;
    n = 0;
    while (!m_busy[k] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    req_valid[k] = 1'b0;
    if (!m_busy[k]) begin
      timeout_fail("accept", k);
      return;
    end
    n = 0;
    while (!m_resp[k] && n < 50) begin
      n++;
      if (n == wr_off) begin
        wr_en   = 1'b1;
        wr_addr = wa;
        wr_data = wd;
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
    end
    if (!m_resp[k]) begin
      timeout_fail("response", k);
      return;
    end
    repeat (stall) @(posedge clk);
    if (stall > 0) #1;
    resp_ready[k] = 1'b1;
    n = 0;
    while (m_busy[k] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    resp_ready[k] = 1'b0;
    if (m_busy[k]) timeout_fail("handshake", k);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  wa;
    int          sel;
    int          k;

    reset       = 1'b0;
    req_valid   = 2'b00;
    resp_ready  = 2'b00;
    req_addr[0] = 32'h0;
    req_addr[1] = 32'h0;
    wr_en       = 1'b0;
    wr_addr     = 8'h0;
    wr_data     = 32'h0;

    repeat (3) begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        check_output("rst_resp_instr", j, resp_instr_a[j], 32'h0);
        check_output("rst_resp_err", j, 32'(resp_err_a[j]), 32'h0);
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;

    $display("[TB] load and basic fetch with backpressure");
    apply_write(8'd0, 32'h2008_0005);
    apply_write(8'd1, 32'h2109_0001);
    apply_write(8'd255, 32'h8FA2_0010);
    apply_fetch(0, 32'h0000_0004, 5, 0, 8'd0, 32'h0);

    $display("[TB] error cases");
    apply_fetch(0, 32'h0000_0006, 0, 0, 8'd0, 32'h0);
    apply_fetch(0, 32'h0000_0400, 1, 0, 8'd0, 32'h0);
    apply_fetch(0, 32'h0000_03FC, 0, 0, 8'd0, 32'h0);

    $display("[TB] write/read collision");
    apply_write(8'd0, 32'hAAAA_AAAA);
    apply_fetch(0, 32'h0000_0000, 0, 2, 8'd0, 32'hBBBB_BBBB);
    apply_write(8'd0, 32'hAAAA_AAAA);
    apply_fetch(0, 32'h0000_0000, 0, 1, 8'd0, 32'hBBBB_BBBB);

    $display("[TB] reset during WAIT");
    req_addr[0]  = 32'h0000_0004;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    apply_fetch(0, 32'h0000_0004, 1, 0, 8'd0, 32'h0);

    $display("[TB] LATENCY=1 instance");
    apply_fetch(1, 32'h0000_0004, 0, 0, 8'd0, 32'h0);
    apply_fetch(1, 32'h0000_0000, 2, 0, 8'd0, 32'h0);
    apply_fetch(1, 32'h0000_0007, 0, 0, 8'd0, 32'h0);
    apply_fetch(1, 32'h0000_03FC, 0, 1, 8'd255, 32'h1234_5678);

    $display("[TB] randomized fetches");
    for (int i = 0; i < 256; i++) apply_write(8'(i), 32'($urandom));
    for (int i = 0; i < 60; i++) begin
      k   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0, 1:    a = {22'd0, 8'($urandom), 2'b00};
        2:       a = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
        default: a = 32'($urandom) | (32'h400 << $urandom_range(0, 21));
      endcase
      wa = ($urandom_range(0, 1) == 1) ? a[9:2] : 8'($urandom);
      apply_fetch(k, a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  wa, 32'($urandom));
      repeat (int'($urandom_range(0, 2))) @(posedge clk);
      #1;
    end

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
